// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: loadable up/down counter sequenced by an IDLE/RUN/HOLD/DONE FSM.
// Latency: count loads on the start edge; done pulses one edge after count matches term_val.
// Backpressure: pause freezes the count (HOLD); stop aborts to IDLE with no done pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a sequence (IDLE only), captures load_val
//   stop, pause         abort / freeze (RUN and HOLD only)
//   up_dn               1 = increment, 0 = decrement (sampled each RUN cycle)
//   load_val, term_val  start value and live terminal value
//   count               registered counter value
//   upper               count MSB
//   busy                registered, high in RUN and HOLD
//   done                registered one-cycle pulse in DONE
//   wrap                registered one-cycle pulse after a wrap-around step
module count_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] term_val,
   output logic [WIDTH-1:0] count,
   output logic             upper,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [WIDTH-1:0] CNT_ZERO = '0;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             wrap_nxt;

   // State register. busy/done/wrap are registered from next-state
   // decodes so every output except upper comes straight off a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         wrap  <= wrap_nxt;
      end
   end

   // Next-state logic; stop beats pause beats terminal compare.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            if (stop)                   state_nxt = IDLE;
            else if (pause)             state_nxt = HOLD;
            else if (count == term_val) state_nxt = DONE;
         end
         HOLD: begin
            if (stop)        state_nxt = IDLE;
            else if (!pause) state_nxt = RUN;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      busy_nxt  = (state_nxt == RUN) || (state_nxt == HOLD);
      done_nxt  = (state_nxt == DONE);
      if (state == IDLE && start) begin
         count_nxt = load_val;
      end else if (state == RUN && !stop && !pause && count != term_val) begin
         if (up_dn) begin
            count_nxt = count + 1'b1;
            wrap_nxt  = (count == CNT_MAX);
         end else begin
            count_nxt = count - 1'b1;
            wrap_nxt  = (count == CNT_ZERO);
         end
      end
   end

   assign upper = count[WIDTH-1];

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Testbench for count_seq_ctrl: directed sequences with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: pause/stop exercised directly through directed steps.
module tb_count_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       pause;
   logic       up_dn;
   logic [3:0] load_val;
   logic [3:0] term_val;
   logic [3:0] count;
   logic       upper;
   logic       busy;
   logic       done;
   logic       wrap;

   int errors = 0;
   int checks = 0;

   count_seq_ctrl #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .up_dn    (up_dn),
      .load_val (load_val),
      .term_val (term_val),
      .count    (count),
      .upper    (upper),
      .busy     (busy),
      .done     (done),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check count/busy/done/wrap together.
   task automatic chk_all(input string tag, input logic [3:0] c, input logic b,
                          input logic d, input logic w);
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".done"},  32'(done),  32'(d));
      chk({tag, ".wrap"},  32'(wrap),  32'(w));
      chk({tag, ".upper"}, 32'(upper), 32'(c[3]));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; up_dn = 1'b1;
      load_val = 4'd0; term_val = 4'd0;

      // Reset state
      #12;
      chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;

      // Up count 3..7
      load_val = 4'd3; term_val = 4'd7; up_dn = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      chk_all("up_load", 4'd3, 1'b1, 1'b0, 1'b0);
      step(); chk_all("up_4", 4'd4, 1'b1, 1'b0, 1'b0);
      step(); chk_all("up_5", 4'd5, 1'b1, 1'b0, 1'b0);
      step(); chk_all("up_6", 4'd6, 1'b1, 1'b0, 1'b0);
      step(); chk_all("up_7", 4'd7, 1'b1, 1'b0, 1'b0);
      step(); chk_all("up_done", 4'd7, 1'b0, 1'b1, 1'b0);
      step(); chk_all("up_idle", 4'd7, 1'b0, 1'b0, 1'b0);

      // Down count with wrap 1,0,15,14
      load_val = 4'd1; term_val = 4'd14; up_dn = 1'b0; start = 1'b1;
      step(); start = 1'b0;
      chk_all("dn_load", 4'd1, 1'b1, 1'b0, 1'b0);
      step(); chk_all("dn_0", 4'd0, 1'b1, 1'b0, 1'b0);
      step(); chk_all("dn_15", 4'd15, 1'b1, 1'b0, 1'b1);
      step(); chk_all("dn_14", 4'd14, 1'b1, 1'b0, 1'b0);
      step(); chk_all("dn_done", 4'd14, 1'b0, 1'b1, 1'b0);
      step(); chk_all("dn_idle", 4'd14, 1'b0, 1'b0, 1'b0);

      // Up wrap 14,15,0,1
      load_val = 4'd14; term_val = 4'd1; up_dn = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      chk_all("uw_load", 4'd14, 1'b1, 1'b0, 1'b0);
      step(); chk_all("uw_15", 4'd15, 1'b1, 1'b0, 1'b0);
      step(); chk_all("uw_0", 4'd0, 1'b1, 1'b0, 1'b1);
      step(); chk_all("uw_1", 4'd1, 1'b1, 1'b0, 1'b0);
      step(); chk_all("uw_done", 4'd1, 1'b0, 1'b1, 1'b0);
      step(); chk_all("uw_idle", 4'd1, 1'b0, 1'b0, 1'b0);

      // Pause at count 5 for 3 cycles
      load_val = 4'd3; term_val = 4'd15; up_dn = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      step(); step();
      chk_all("ps_5", 4'd5, 1'b1, 1'b0, 1'b0);
      pause = 1'b1;
      step(); chk_all("ps_hold1", 4'd5, 1'b1, 1'b0, 1'b0);
      step(); chk_all("ps_hold2", 4'd5, 1'b1, 1'b0, 1'b0);
      step(); chk_all("ps_hold3", 4'd5, 1'b1, 1'b0, 1'b0);
      pause = 1'b0;
      step(); chk_all("ps_run", 4'd5, 1'b1, 1'b0, 1'b0);
      step(); chk_all("ps_6", 4'd6, 1'b1, 1'b0, 1'b0);
      stop = 1'b1;
      step(); stop = 1'b0;
      chk_all("ps_stop", 4'd6, 1'b0, 1'b0, 1'b0);

      // Stop + pause + start together at count 9
      load_val = 4'd7; term_val = 4'd0; up_dn = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      step(); step();
      chk_all("sp_9", 4'd9, 1'b1, 1'b0, 1'b0);
      stop = 1'b1; pause = 1'b1; start = 1'b1; load_val = 4'd2;
      step(); stop = 1'b0; pause = 1'b0; start = 1'b0;
      chk_all("sp_idle", 4'd9, 1'b0, 1'b0, 1'b0);
      step(); chk_all("sp_hold_idle", 4'd9, 1'b0, 1'b0, 1'b0);

      // Async reset mid-RUN at count 12
      load_val = 4'd10; term_val = 4'd5; up_dn = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      step(); step();
      chk_all("ar_12", 4'd12, 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 chk_all("ar_async", 4'd0, 1'b0, 1'b0, 1'b0);
      step(); chk_all("ar_held", 4'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // First edge after reset samples start; immediate terminal 10
      load_val = 4'd10; term_val = 4'd10; up_dn = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      chk_all("it_load", 4'd10, 1'b1, 1'b0, 1'b0);
      step(); chk_all("it_done", 4'd10, 1'b0, 1'b1, 1'b0);
      step(); chk_all("it_idle", 4'd10, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  begin a count sequence; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort the current sequence; sampled in RUN and HOLD.
REQ-006 Port: pause  input  1  freeze counting while high; sampled in RUN and HOLD.
REQ-007 Port: up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled every RUN cycle.
REQ-008 Port: load_val  input  WIDTH  start value, captured on the accepted start edge.
REQ-009 Port: term_val  input  WIDTH  terminal value, compared live every RUN cycle.
REQ-010 Port: count  output  WIDTH  registered counter value.
REQ-011 Port: upper  output  1  count[WIDTH-1], i.e. count >= 8 for WIDTH=4.
REQ-012 Port: busy  output  1  high in RUN and HOLD only.
REQ-013 Port: done  output  1  one-cycle pulse when the terminal value is reached.
REQ-014 Port: wrap  output  1  one-cycle registered pulse on counter wrap-around.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, HOLD and DONE.
REQ-016 IDLE: count SHALL hold its value; if start=1, count <= load_val and next state = RUN.
REQ-017 RUN, in priority order:
- stop=1 -> IDLE, count held, no done.
- else pause=1 -> HOLD, count held.
- else count == term_val -> DONE, count held.
- else count <= count+1 (up_dn=1) or count-1 (up_dn=0), modulo 2^WIDTH.
REQ-018 HOLD:
- stop=1 -> IDLE.
- else pause=0 -> RUN.
- count SHALL be held in both cases.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE; start SHALL be ignored while in DONE.
REQ-020 done SHALL be 1 only while in DONE.
REQ-021 start SHALL be ignored in RUN, HOLD and DONE; stop and pause SHALL be ignored in IDLE and DONE.
REQ-022 Wrap-around:
- Increment from 2^WIDTH-1 SHALL give 0; decrement from 0 SHALL give 2^WIDTH-1.
- wrap SHALL be 1 during the cycle after either wrap transition, otherwise 0.
REQ-023 Latency: if load_val == term_val, done SHALL assert two edges after the start edge (load edge, then the RUN->DONE edge).
REQ-024 A term_val change mid-RUN SHALL take effect at the next compare; if it is never matched, counting SHALL continue and wrap indefinitely.
REQ-025 upper SHALL be derived combinationally from the registered count and SHALL be glitch-free relative to count.
REQ-026 All outputs except upper SHALL be driven directly from registers.

Reset
REQ-027 While rst=1, the block SHALL force: state=IDLE, count=0, busy=0, done=0, wrap=0, upper=0, independent of clk.
REQ-028 When rst asserts mid-sequence (RUN, HOLD or DONE), the block SHALL abort immediately with no done pulse.
REQ-029 On the first rising edge after rst deasserts, the block SHALL sample start normally.

Verification
REQ-030 Up count: load_val=3, term_val=7, up_dn=1, start pulse.
- count = 3,4,5,6,7 on consecutive edges.
- done=1 for one cycle with count=7; then IDLE, busy=0.
REQ-031 Down wrap: load_val=1, term_val=14, up_dn=0.
- count = 1,0,15,14.
- wrap=1 for the one cycle after 0->15; done with count=14.
REQ-032 Pause: during RUN at count=5, pause high for 3 cycles.
- count stays 5 and busy=1 throughout.
- After pause drops, counting resumes at 6.
REQ-033 Stop/start priority: stop and pause asserted together in RUN at count=9.
- Next state IDLE, count=9, upper=1, done never asserts.
- start asserted at the same time is ignored until IDLE is reached.
REQ-034 Async reset: rst pulsed between clock edges while in RUN at count=12.
- count=0, busy=0 and upper=0 before the next clk edge.
- No done pulse follows.
REQ-035 Immediate terminal: load_val=term_val=10.
- done asserts on the second edge after start.
- count stays 10 throughout; wrap stays 0.
